// File: rtl/vid_count_pkg.sv
// Shared constants for the video counter/decode stage: default widths, prescale bound, decode values.
// No logic of its own; dec_hit() is the equality compare used for every decode flag.
// Compile-time only, so there is no latency and no backpressure.
package vid_count_pkg;

    localparam int PCNT_W_DEF = 8;
    localparam int CNT_W_DEF  = 10;
    localparam int PDIV_DEF   = 1;
    localparam int PDIV_MIN   = 1;
    localparam int PDIV_MAX   = 16;

    localparam int PCNT_D6   = 6;
    localparam int PCNT_D12  = 12;
    localparam int PCNT_D17  = 17;
    localparam int PCNT_D27  = 27;
    localparam int PCNT_D241 = 241;

    localparam int CNT_D10  = 10;
    localparam int CNT_D13  = 13;
    localparam int CNT_D21  = 21;
    localparam int CNT_D44  = 44;
    localparam int CNT_D45  = 45;
    localparam int CNT_D261 = 261;
    localparam int CNT_D272 = 272;
    localparam int CNT_D283 = 283;
    localparam int CNT_D284 = 284;
    localparam int CNT_D509 = 509;
    localparam int CNT_D511 = 511;
    localparam int CNT_D567 = 567;
    localparam int CNT_D591 = 591;

    // A decode value that cannot fit in a w-bit counter never matches, rather than aliasing.
    function automatic logic dec_hit(input logic [31:0] val, input int unsigned dv,
                                     input int unsigned w);
        if (w < 32 && dv >= (32'd1 << w))
            return 1'b0;
        return val == dv;
    endfunction

endpackage

// File: rtl/vid_prescale.sv
// Pixel-rate prescaler: divides CK by PDIV and emits a one-cycle ptick.
// ptick is registered: high in the cycle the prescaler sits at PDIV-1.
// Free-running, no backpressure; only RST restarts it.
module vid_prescale
    import vid_count_pkg::*;
#(
    parameter int PDIV = PDIV_DEF
) (
    input  logic CK,
    input  logic RST,
    output logic ptick
);

    // Out-of-range PDIV is clamped into the supported 1..16 window.
    localparam int PDIV_EFF = (PDIV < PDIV_MIN) ? PDIV_MIN :
                              (PDIV > PDIV_MAX) ? PDIV_MAX : PDIV;
    localparam int PS_W = (PDIV_EFF > 1) ? $clog2(PDIV_EFF) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PDIV_EFF - 1);

    logic [PS_W-1:0] ps;
    logic [PS_W-1:0] ps_nxt;

    always_comb begin
        ps_nxt = (ps == PS_LAST) ? '0 : ps + PS_W'(1);
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            ps    <= '0;
            ptick <= 1'b0;
        end else begin
            ps    <= ps_nxt;
            ptick <= (ps_nxt == PS_LAST);
        end
    end

endmodule

// File: rtl/vid_count_decode.sv
// Pixel and line counters with single-value decode flags for the video sync controller.
// Counters update one edge after pclr/pc/cclr; flags follow the registered counts with no added latency.
// No backpressure: every cycle is valid, clears win over counts, and a pc edge lost to cclr is not replayed.
module vid_count_decode
    import vid_count_pkg::*;
#(
    parameter int PCNT_W = PCNT_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int PDIV   = PDIV_DEF
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              pclr,
    input  logic              pc,
    input  logic              cclr,
    output logic              ptick,
    output logic [PCNT_W-1:0] pcnt,
    output logic [CNT_W-1:0]  cnt,
    output logic              pcnt6,
    output logic              pcnt12,
    output logic              pcnt17,
    output logic              pcnt27,
    output logic              pcnt241,
    output logic              cnt10,
    output logic              cnt13,
    output logic              cnt21,
    output logic              cnt44,
    output logic              cnt45,
    output logic              cnt261,
    output logic              cnt272,
    output logic              cnt283,
    output logic              cnt284,
    output logic              cnt509,
    output logic              cnt511,
    output logic              cnt567,
    output logic              cnt591,
    output logic              cnt_ovf
);

    logic        pc_d;
    logic        pc_rise;
    logic [31:0] pcnt_ext;
    logic [31:0] cnt_ext;

    vid_prescale #(
        .PDIV (PDIV)
    ) u_prescale (
        .CK    (CK),
        .RST   (RST),
        .ptick (ptick)
    );

    assign pc_rise = pc & ~pc_d;

    always_ff @(posedge CK) begin
        if (RST)
            pcnt <= '0;
        else if (pclr)
            pcnt <= '0;
        else if (ptick)
            pcnt <= pcnt + PCNT_W'(1);
    end

    // pc_d tracks pc even while cclr is high, so an edge swallowed by the clear is gone for good.
    always_ff @(posedge CK) begin
        if (RST) begin
            pc_d    <= 1'b0;
            cnt     <= '0;
            cnt_ovf <= 1'b0;
        end else begin
            pc_d <= pc;
            if (cclr) begin
                cnt     <= '0;
                cnt_ovf <= 1'b0;
            end else if (pc_rise) begin
                cnt     <= cnt + CNT_W'(1);
                cnt_ovf <= cnt_ovf | (&cnt);
            end
        end
    end

    assign pcnt_ext = 32'(pcnt);
    assign cnt_ext  = 32'(cnt);

    assign pcnt6   = dec_hit(pcnt_ext, PCNT_D6,   PCNT_W);
    assign pcnt12  = dec_hit(pcnt_ext, PCNT_D12,  PCNT_W);
    assign pcnt17  = dec_hit(pcnt_ext, PCNT_D17,  PCNT_W);
    assign pcnt27  = dec_hit(pcnt_ext, PCNT_D27,  PCNT_W);
    assign pcnt241 = dec_hit(pcnt_ext, PCNT_D241, PCNT_W);

    assign cnt10  = dec_hit(cnt_ext, CNT_D10,  CNT_W);
    assign cnt13  = dec_hit(cnt_ext, CNT_D13,  CNT_W);
    assign cnt21  = dec_hit(cnt_ext, CNT_D21,  CNT_W);
    assign cnt44  = dec_hit(cnt_ext, CNT_D44,  CNT_W);
    assign cnt45  = dec_hit(cnt_ext, CNT_D45,  CNT_W);
    assign cnt261 = dec_hit(cnt_ext, CNT_D261, CNT_W);
    assign cnt272 = dec_hit(cnt_ext, CNT_D272, CNT_W);
    assign cnt283 = dec_hit(cnt_ext, CNT_D283, CNT_W);
    assign cnt284 = dec_hit(cnt_ext, CNT_D284, CNT_W);
    assign cnt509 = dec_hit(cnt_ext, CNT_D509, CNT_W);
    assign cnt511 = dec_hit(cnt_ext, CNT_D511, CNT_W);
    assign cnt567 = dec_hit(cnt_ext, CNT_D567, CNT_W);
    assign cnt591 = dec_hit(cnt_ext, CNT_D591, CNT_W);

endmodule

// File: tb/tb_vid_count_decode.sv
// Bench for vid_count_decode: PDIV=1 and PDIV=4 instances checked every cycle against a reference model.
// A reset/clear vector table plus hand sequences exercise wrap, overflow and clear-vs-count corners.
module tb_vid_count_decode;

    logic CK = 1'b0;
    always #5 CK = ~CK;

    logic RST = 1'b1, pclr = 1'b0, pc = 1'b0, cclr = 1'b0, pclr4 = 1'b0;

    logic       ptick, cnt_ovf;
    logic [7:0] pcnt;
    logic [9:0] cnt;
    logic pcnt6, pcnt12, pcnt17, pcnt27, pcnt241;
    logic cnt10, cnt13, cnt21, cnt44, cnt45, cnt261, cnt272, cnt283, cnt284;
    logic cnt509, cnt511, cnt567, cnt591;

    logic        ptick4, ovf4;
    logic [7:0]  pcnt4;
    logic [9:0]  cnt_4;
    logic [4:0]  pf4;
    logic [12:0] cf4;

    vid_count_decode #(.PCNT_W(8), .CNT_W(10), .PDIV(1)) dut (
        .CK(CK), .RST(RST), .pclr(pclr), .pc(pc), .cclr(cclr),
        .ptick(ptick), .pcnt(pcnt), .cnt(cnt),
        .pcnt6(pcnt6), .pcnt12(pcnt12), .pcnt17(pcnt17), .pcnt27(pcnt27), .pcnt241(pcnt241),
        .cnt10(cnt10), .cnt13(cnt13), .cnt21(cnt21), .cnt44(cnt44), .cnt45(cnt45),
        .cnt261(cnt261), .cnt272(cnt272), .cnt283(cnt283), .cnt284(cnt284),
        .cnt509(cnt509), .cnt511(cnt511), .cnt567(cnt567), .cnt591(cnt591),
        .cnt_ovf(cnt_ovf)
    );

    vid_count_decode #(.PCNT_W(8), .CNT_W(10), .PDIV(4)) dut4 (
        .CK(CK), .RST(RST), .pclr(pclr4), .pc(pc), .cclr(cclr),
        .ptick(ptick4), .pcnt(pcnt4), .cnt(cnt_4),
        .pcnt6(pf4[0]), .pcnt12(pf4[1]), .pcnt17(pf4[2]), .pcnt27(pf4[3]), .pcnt241(pf4[4]),
        .cnt10(cf4[0]), .cnt13(cf4[1]), .cnt21(cf4[2]), .cnt44(cf4[3]), .cnt45(cf4[4]),
        .cnt261(cf4[5]), .cnt272(cf4[6]), .cnt283(cf4[7]), .cnt284(cf4[8]),
        .cnt509(cf4[9]), .cnt511(cf4[10]), .cnt567(cf4[11]), .cnt591(cf4[12]),
        .cnt_ovf(ovf4)
    );

    typedef struct {
        int          pcnt;
        int          cnt;
        logic        ptick;
        logic        ovf;
        logic [4:0]  pf;
        logic [12:0] cf;
        int          pcnt4;
        logic        ptick4;
    } exp_t;

    typedef struct {
        logic r, pcl, p, cc;
        int   epcnt, ecnt;
        logic etick;
    } vec_t;

    exp_t sbq[$];
    int   nvec = 0;
    int   nerr = 0;

    int   m_pcnt = 0, m_cnt = 0, m4_pcnt = 0, m_ps4 = 0;
    logic m_ptick = 1'b0, m_pcd = 1'b0, m_ovf = 1'b0, m_ptick4 = 1'b0;

    function automatic logic [4:0] pflags(input int v);
        return {v == 241, v == 27, v == 17, v == 12, v == 6};
    endfunction

    function automatic logic [12:0] cflags(input int v);
        return {v == 591, v == 567, v == 511, v == 509, v == 284, v == 283, v == 272,
                v == 261, v == 45, v == 44, v == 21, v == 13, v == 10};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic pcl, input logic p,
                              input logic cc, input logic pcl4);
        exp_t e;
        if (r) begin
            m_pcnt = 0; m_cnt = 0; m4_pcnt = 0; m_ps4 = 0;
            m_ptick = 0; m_pcd = 0; m_ovf = 0; m_ptick4 = 0;
        end else begin
            if (pcl)          m_pcnt = 0;
            else if (m_ptick) m_pcnt = (m_pcnt + 1) % 256;
            m_ptick = 1'b1;
            if (pcl4)          m4_pcnt = 0;
            else if (m_ptick4) m4_pcnt = (m4_pcnt + 1) % 256;
            m_ps4    = (m_ps4 + 1) % 4;
            m_ptick4 = (m_ps4 == 3);
            if (cc) begin
                m_cnt = 0;
                m_ovf = 1'b0;
            end else if (p && !m_pcd) begin
                if (m_cnt == 1023) begin
                    m_cnt = 0;
                    m_ovf = 1'b1;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
            m_pcd = p;
        end
        e.pcnt = m_pcnt; e.cnt = m_cnt; e.ptick = m_ptick; e.ovf = m_ovf;
        e.pf = pflags(m_pcnt); e.cf = cflags(m_cnt);
        e.pcnt4 = m4_pcnt; e.ptick4 = m_ptick4;
        sbq.push_back(e);
    endtask

    task automatic cycle(input logic r, input logic pcl, input logic p,
                         input logic cc, input logic pcl4);
        exp_t e;
        @(negedge CK);
        RST = r; pclr = pcl; pc = p; cclr = cc; pclr4 = pcl4;
        model_step(r, pcl, p, cc, pcl4);
        @(posedge CK);
        #1;
        e = sbq.pop_front();
        chk("pcnt",   32'(pcnt),    32'(e.pcnt));
        chk("cnt",    32'(cnt),     32'(e.cnt));
        chk("ptick",  32'(ptick),   32'(e.ptick));
        chk("ovf",    32'(cnt_ovf), 32'(e.ovf));
        chk("pflags", 32'({pcnt241, pcnt27, pcnt17, pcnt12, pcnt6}), 32'(e.pf));
        chk("cflags", 32'({cnt591, cnt567, cnt511, cnt509, cnt284, cnt283, cnt272,
                           cnt261, cnt45, cnt44, cnt21, cnt13, cnt10}), 32'(e.cf));
        chk("pcnt4",  32'(pcnt4),   32'(e.pcnt4));
        chk("ptick4", 32'(ptick4),  32'(e.ptick4));
    endtask

    task automatic pulse();
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);
    endtask

    initial begin
        vec_t tbl[12];
        int   guard;
        int   n6, n12, n17, n27, n241, wraps, ticks4, prev;
        logic done4, c4;

        // Reset, first tick, edge detect, clears and clear-vs-edge races from a clean start.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 1, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 1, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2, 1, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3, 0, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4, 0, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2, 1, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 1, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 1, 1'b1};
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].r, tbl[i].pcl, tbl[i].p, tbl[i].cc, 1'b0);
            chk("tbl_pcnt",  32'(pcnt),  32'(tbl[i].epcnt));
            chk("tbl_cnt",   32'(cnt),   32'(tbl[i].ecnt));
            chk("tbl_ptick", 32'(ptick), 32'(tbl[i].etick));
        end

        // Mid-count reset held for three cycles.
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) pulse();
        guard = 0;
        while (m_pcnt != 100 && guard < 300) begin
            cycle(0, 0, 0, 0, 0);
            guard++;
        end
        chk("pre_rst_pcnt", 32'(pcnt), 32'd100);
        chk("pre_rst_cnt",  32'(cnt),  32'd300);
        for (int i = 0; i < 3; i++) cycle(1, 0, 1, 0, 0);
        chk("rst_pcnt",  32'(pcnt),    32'd0);
        chk("rst_cnt",   32'(cnt),     32'd0);
        chk("rst_ovf",   32'(cnt_ovf), 32'd0);
        chk("rst_flags", 32'({pcnt6, pcnt12, pcnt17, pcnt27, pcnt241, cnt10, cnt13, cnt21,
                              cnt44, cnt45, cnt261, cnt272, cnt283, cnt284, cnt509, cnt511,
                              cnt567, cnt591}), 32'd0);

        // Free-running pixel count through wrap; PDIV=4 instance cleared on the tick at 17.
        n6 = 0; n12 = 0; n17 = 0; n27 = 0; n241 = 0; wraps = 0; ticks4 = 0; prev = 0;
        done4 = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            c4 = !done4 && m_ptick4 && (m4_pcnt == 17);
            cycle(0, 0, 0, 0, c4);
            if (c4) begin
                done4 = 1'b1;
                chk("pclr_on_tick", 32'(pcnt4), 32'd0);
            end
            if (i <= 256) begin
                n6 += int'(pcnt6); n12 += int'(pcnt12); n17 += int'(pcnt17);
                n27 += int'(pcnt27); n241 += int'(pcnt241);
            end
            if (prev == 255 && pcnt == 8'd0) wraps++;
            prev = int'(pcnt);
            ticks4 += int'(ptick4);
        end
        chk("pcnt6_once",   n6,     1);
        chk("pcnt12_once",  n12,    1);
        chk("pcnt17_once",  n17,    1);
        chk("pcnt27_once",  n27,    1);
        chk("pcnt241_once", n241,   1);
        chk("pcnt_wrap",    wraps,  1);
        chk("ptick4_count", ticks4, 75);
        chk("pclr4_seen",   32'(done4), 32'd1);

        // Line counter: pulse train to 591, then a long pc level counts once.
        for (int i = 0; i < 591; i++) pulse();
        chk("cnt_591",  32'(cnt),    32'd591);
        chk("flag_591", 32'(cnt591), 32'd1);
        for (int i = 0; i < 20; i++) cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);
        chk("held_pc", 32'(cnt), 32'd592);

        // Wrap at 1023, sticky overflow, and cclr racing a pc edge.
        guard = 0;
        while (m_cnt != 1023 && guard < 1000) begin
            pulse();
            guard++;
        end
        chk("cnt_max", 32'(cnt), 32'd1023);
        cycle(0, 0, 1, 0, 0);
        chk("wrap_cnt", 32'(cnt),     32'd0);
        chk("wrap_ovf", 32'(cnt_ovf), 32'd1);
        cycle(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) pulse();
        chk("ovf_sticky_cnt", 32'(cnt),     32'd3);
        chk("ovf_sticky",     32'(cnt_ovf), 32'd1);
        cycle(0, 0, 1, 1, 0);
        chk("cclr_cnt", 32'(cnt),     32'd0);
        chk("cclr_ovf", 32'(cnt_ovf), 32'd0);
        cycle(0, 0, 1, 0, 0);
        chk("edge_lost", 32'(cnt), 32'd0);
        cycle(0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
